// File: rtl/mem_responder_if.sv
// CPU <-> memory bus for mem_responder.
//   addr     16  CPU address (from CPU AR)
//   wr_data   8  CPU write data
//   read      1  read request, level, sampled every cycle
//   write     1  write request, level, sampled every cycle
//   rd_data   8  registered read data returned to the CPU
//   oor       1  one-cycle flag: out-of-range access or read+write together
// The master modport is the CPU side and the slave modport is the memory side.
interface mem_responder_if;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        read;
  logic        write;
  logic [7:0]  rd_data;
  logic        oor;

  modport master (
    output addr, wr_data, read, write,
    input  rd_data, oor
  );

  modport slave (
    input  addr, wr_data, read, write,
    output rd_data, oor
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder that owns the program/data store.
//   RUN   (10): serves CPU reads and writes on the bus. Reads have one cycle of latency.
//   LOAD  (01): each rising edge of sw_step writes sw_data to store[ptr], then ptr advances.
//   CHECK (11): insp_data follows store[ptr] every cycle, and sw_step advances ptr.
//   IDLE  (00): nothing happens and the outputs hold.
// Ports:
//   clk        system clock. All state changes on the rising edge.
//   rst        asynchronous reset, active-low.
//   cpustate   requested mode. A registered copy of it is used from the next edge.
//   bus        CPU bus (slave side): addr, wr_data, read, write, rd_data, oor.
//   sw_data    switch data used in LOAD mode.
//   sw_step    step button, a synchronous level. Only its rising edge is used.
//   ptr        LOAD/CHECK pointer, zero-extended to 16 bits for the display.
//   insp_data  byte at ptr in CHECK mode (registered).
module mem_responder #(
  parameter int          AW    = 8,
  parameter logic [7:0]  INIT0 = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cpustate,
  mem_responder_if.slave   bus,
  input  logic [7:0]       sw_data,
  input  logic             sw_step,
  output logic [15:0]      ptr,
  output logic [7:0]       insp_data
);

  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_RUN   = 2'b10;
  localparam logic [1:0] MODE_CHECK = 2'b11;

  logic [7:0]    store [0:DEPTH-1];

  logic [1:0]    mode;
  logic          step_q;
  logic [AW-1:0] ptr_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    insp_q;
  logic          oor_q;

  logic          step_rise;
  logic          entering_ptr_mode;
  logic          addr_oob;
  logic          run_read;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  assign step_rise = sw_step & ~step_q;

  // ptr restarts from 0 only when the mode moves into LOAD or CHECK from a
  // different mode. Switching between LOAD and CHECK also restarts it.
  assign entering_ptr_mode = (cpustate != mode) &&
                             ((cpustate == MODE_LOAD) || (cpustate == MODE_CHECK));

  // Any address bit at or above AW puts the access outside the store.
  assign addr_oob = ((32'(bus.addr) >> AW) != 32'd0);

  // A read that happens together with a write is dropped, so rd_data holds.
  assign run_read = (mode == MODE_RUN) && bus.read && !bus.write;

  // Single store write port, shared by CPU writes in RUN and switch loads in LOAD.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if ((mode == MODE_RUN) && bus.write && !addr_oob) begin
      mem_we    = 1'b1;
      mem_waddr = bus.addr[AW-1:0];
      mem_wdata = bus.wr_data;
    end else if ((mode == MODE_LOAD) && step_rise) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = sw_data;
    end
  end

  // NOTE: the store has no reset. Its contents must survive rst, and without
  // a reset it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      store[mem_waddr] <= mem_wdata;
    end
  end

  // NOTE: all registered state uses non-blocking assignments. Every register
  // then samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode      <= MODE_IDLE;
      step_q    <= 1'b0;
      ptr_q     <= '0;
      rd_data_q <= INIT0;
      insp_q    <= INIT0;
      oor_q     <= 1'b0;
    end else begin
      mode   <= cpustate;
      // The edge detector runs in every mode. A button that is already held
      // when LOAD or CHECK is entered therefore does not count as a step.
      step_q <= sw_step;

      if (entering_ptr_mode) begin
        ptr_q <= '0;
      end else if (((mode == MODE_LOAD) || (mode == MODE_CHECK)) && step_rise) begin
        ptr_q <= ptr_q + AW'(1);
      end

      if (run_read) begin
        rd_data_q <= addr_oob ? 8'h00 : store[bus.addr[AW-1:0]];
      end

      if (mode == MODE_CHECK) begin
        insp_q <= store[ptr_q];
      end

      oor_q <= (mode == MODE_RUN) &&
               (((bus.read || bus.write) && addr_oob) || (bus.read && bus.write));
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.oor     = oor_q;
  assign ptr         = 16'(ptr_q);
  assign insp_data   = insp_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam logic [1:0] M_IDLE = 2'b00, M_LOAD = 2'b01, M_RUN = 2'b10, M_CHECK = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cpustate;
  logic [7:0]  sw_data;
  logic        sw_step;
  logic [15:0] ptr;
  logic [7:0]  insp_data;

  mem_responder_if bus ();

  mem_responder #(.AW(8), .INIT0(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpustate  (cpustate),
    .bus       (bus),
    .sw_data   (sw_data),
    .sw_step   (sw_step),
    .ptr       (ptr),
    .insp_data (insp_data)
  );

  always #5 clk = ~clk;

  // Reference model: the contents of the store, the pointer and the expected rd_data.
  logic [7:0]  model_mem [256];
  int          model_ptr;
  logic [7:0]  exp_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Each tick ends 1 ns after a rising edge. All checks and input changes happen there.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    cpustate = m;
    tick(1);
    if (m == M_LOAD || m == M_CHECK) model_ptr = 0;
  endtask

  // One button press in LOAD or CHECK. The model only changes the store in LOAD.
  task automatic press(input logic [7:0] d, input bit is_load);
    sw_data = d;
    sw_step = 1'b1;
    tick(1);
    sw_step = 1'b0;
    tick(1);
    if (is_load) model_mem[model_ptr] = d;
    model_ptr = (model_ptr + 1) % 256;
  endtask

  task automatic bus_idle();
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
  endtask

  // One RUN cycle with the given request. The model predicts rd_data and oor.
  task automatic run_cycle(input bit r, input bit w, input logic [15:0] a,
                           input logic [7:0] d, input string name);
    bit oob;
    bit exp_oor;
    oob     = (a >= 16'd256);
    exp_oor = ((r || w) && oob) || (r && w);
    if (r && !w) exp_rd = oob ? 8'h00 : model_mem[a % 256];
    if (w && !oob) model_mem[a % 256] = d;
    bus.read = r; bus.write = w; bus.addr = a; bus.wr_data = d;
    tick(1);
    bus_idle();
    n_checks++;
    if (bus.rd_data !== exp_rd) begin
      n_fail++;
      $display("FAIL %s rd_data: got %02h want %02h (addr %04h)", name, bus.rd_data, exp_rd, a);
    end
    n_checks++;
    if (bus.oor !== exp_oor) begin
      n_fail++;
      $display("FAIL %s oor: got %0b want %0b (addr %04h r%0b w%0b)", name, bus.oor, exp_oor, a, r, w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cpustate = M_IDLE; sw_data = '0; sw_step = 1'b0;
    bus_idle();
    #3;
    n_checks++;
    if (bus.rd_data !== 8'h00 || insp_data !== 8'h00 || ptr !== 16'h0000 || bus.oor !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%02h insp=%02h ptr=%04h oor=%0b want 00 00 0000 0",
               bus.rd_data, insp_data, ptr, bus.oor);
    end
    tick(2);
    rst = 1'b1;
    exp_rd = 8'h00;
    tick(1);
  endtask

  // Load all 256 bytes with random data so that the model knows every location.
  task automatic test_load_fill();
    set_mode(M_LOAD);
    for (int i = 0; i < 256; i++) press(8'($urandom), 1'b1);
    n_checks++;
    if (ptr !== 16'h0000) begin
      n_fail++;
      $display("FAIL load_wrap ptr: got %04h want 0000", ptr);
    end
  endtask

  task automatic test_load_vectors();
    logic [7:0] vec [3];
    vec[0] = 8'hA5; vec[1] = 8'h3C; vec[2] = 8'hFF;
    set_mode(M_IDLE);
    set_mode(M_LOAD);
    for (int i = 0; i < 3; i++) press(vec[i], 1'b1);
    n_checks++;
    if (ptr !== 16'd3) begin
      n_fail++;
      $display("FAIL load_vectors ptr: got %04h want 0003", ptr);
    end
  endtask

  // While the button is held, sw_data changes every cycle. Only the first value may land.
  task automatic test_load_hold();
    logic [7:0] first;
    first = 8'($urandom);
    sw_data = first;
    sw_step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      sw_data = 8'($urandom);
    end
    sw_step = 1'b0;
    tick(1);
    model_mem[model_ptr] = first;
    model_ptr = model_ptr + 1;
    n_checks++;
    if (ptr !== 16'(model_ptr)) begin
      n_fail++;
      $display("FAIL load_hold ptr: got %04h want %04h", ptr, 16'(model_ptr));
    end
  endtask

  task automatic test_check();
    set_mode(M_CHECK);
    n_checks++;
    if (ptr !== 16'h0000) begin
      n_fail++;
      $display("FAIL check_enter ptr: got %04h want 0000", ptr);
    end
    tick(1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (insp_data !== model_mem[model_ptr]) begin
        n_fail++;
        $display("FAIL check_insp[%0d]: got %02h want %02h", model_ptr, insp_data, model_mem[model_ptr]);
      end
      press(8'($urandom), 1'b0);
    end
    while (model_ptr != 255) press(8'($urandom), 1'b0);
    n_checks++;
    if (ptr !== 16'h00FF || insp_data !== model_mem[255]) begin
      n_fail++;
      $display("FAIL check_last: ptr=%04h insp=%02h want 00ff %02h", ptr, insp_data, model_mem[255]);
    end
    press(8'h00, 1'b0);
    n_checks++;
    if (ptr !== 16'h0000 || insp_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL check_wrap: ptr=%04h insp=%02h want 0000 a5", ptr, insp_data);
    end
  endtask

  task automatic test_run_directed();
    set_mode(M_RUN);
    run_cycle(1'b0, 1'b1, 16'h0010, 8'h5A, "raw_write");
    run_cycle(1'b1, 1'b0, 16'h0010, 8'h00, "raw_read");
    run_cycle(1'b0, 1'b0, 16'h0010, 8'h00, "rd_hold");
    run_cycle(1'b1, 1'b0, 16'h0100, 8'h00, "oob_read");
    run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, "oob_pulse_end");
    run_cycle(1'b1, 1'b0, 16'h0010, 8'h00, "reread");
    run_cycle(1'b1, 1'b1, 16'h0020, 8'h77, "read_and_write");
    run_cycle(1'b1, 1'b0, 16'h0020, 8'h00, "rw_landed");
    run_cycle(1'b0, 1'b1, 16'h0110, 8'hEE, "oob_write");
    run_cycle(1'b1, 1'b0, 16'h0010, 8'h00, "oob_write_ignored");
  endtask

  task automatic test_run_random();
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [15:0] a;
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = {8'($urandom_range(1, 255)), 8'($urandom)};
      else a = {8'h00, 8'($urandom)};
      run_cycle(op[0], op[1], a, 8'($urandom), "run_random");
    end
  endtask

  task automatic test_idle();
    logic [15:0] p;
    set_mode(M_IDLE);
    p = ptr;
    for (int i = 0; i < 4; i++) begin
      bus.read = 1'b1; bus.write = 1'b1; bus.addr = 16'h0030; bus.wr_data = 8'(~model_mem[8'h30]);
      sw_step = i[0];
      tick(1);
      n_checks++;
      if (bus.rd_data !== exp_rd || bus.oor !== 1'b0 || ptr !== p) begin
        n_fail++;
        $display("FAIL idle_hold: rd=%02h oor=%0b ptr=%04h want %02h 0 %04h",
                 bus.rd_data, bus.oor, ptr, exp_rd, p);
      end
    end
    bus_idle();
    sw_step = 1'b0;
    set_mode(M_RUN);
    run_cycle(1'b1, 1'b0, 16'h0030, 8'h00, "idle_no_write");
  endtask

  task automatic test_reset_midload();
    set_mode(M_LOAD);
    for (int i = 0; i < 5; i++) press(8'($urandom), 1'b1);
    n_checks++;
    if (ptr !== 16'd5) begin
      n_fail++;
      $display("FAIL midload ptr: got %04h want 0005", ptr);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    exp_rd = 8'h00;
    n_checks++;
    if (ptr !== 16'h0000 || bus.rd_data !== 8'h00 || insp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: ptr=%04h rd=%02h insp=%02h want 0000 00 00", ptr, bus.rd_data, insp_data);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    tick(2);
    set_mode(M_CHECK);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (insp_data !== model_mem[model_ptr]) begin
        n_fail++;
        $display("FAIL retained[%0d]: got %02h want %02h", model_ptr, insp_data, model_mem[model_ptr]);
      end
      press(8'h00, 1'b0);
    end
  endtask

  initial begin
    model_ptr = 0;
    test_reset();
    test_load_fill();
    test_load_vectors();
    test_load_hold();
    test_check();
    test_run_directed();
    test_run_random();
    test_idle();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
